_counter: RTL

Synchronous binary up-counter whose increment carry chain is built from the team's `_and` multi-input AND-reduce stage. Each count bit toggles when the AND of `enableData` and all lower count bits is 1. The carry out of the top stage is the terminal-count flag. It sits directly upstream of `_and` instances, drives their `inputData`, and consumes their `outputData`. It is the standard event/cycle counter for structural designs powered from `DigitSupply`.

---
 rtl/digit_pkg.sv | 11 +
 rtl/_and.sv | 11 +
 rtl/_counter_bit.sv | 37 +++
 rtl/_counter.sv | 72 +++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared constants for structural designs powered from the DigitSupply rails.
// Rail indices and the legal counter width range live here.
package digit_pkg;

  localparam int DIGIT_HIGH = 1;
  localparam int DIGIT_LOW  = 0;

  localparam int COUNT_WIDTH_MIN = 1;
  localparam int COUNT_WIDTH_MAX = 16;

endpackage : digit_pkg

// File: rtl/_and.sv
// Multi-input AND-reduce stage: outputData is high only when every inputData bit is high.
module _and #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] inputData,
  output logic             outputData
);

  assign outputData = &inputData;

endmodule : _and

// File: rtl/_counter_bit.sv
// One counter bit: toggle flop whose next value is count XOR carry-in,
// overridden by synchronous clear (highest priority) and parallel load.
module _counter_bit (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic low_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic loadBit_i,
  input  logic carry_i,
  output logic count_o
);

  logic count_q;
  logic count_d;

  always_comb begin
    count_d = count_q ^ carry_i;
    if (load_i) begin
      count_d = loadBit_i;
    end
    if (clear_i) begin
      count_d = low_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 1'b0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : _counter_bit

// File: rtl/_counter.sv
// Synchronous binary up-counter with a ripple carry chain of width-2 _and stages.
// terminalCount is the carry out of the top stage; wrapPulse flags the cycle after a wrap.
module _counter
  import digit_pkg::*;
#(
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   Clock,
  input  logic                   ResetN,
  input  logic [1:0]             DigitSupply,
  input  logic                   enableData,
  input  logic                   clearData,
  input  logic                   loadData,
  input  logic [COUNT_WIDTH-1:0] loadValue,
  output logic [COUNT_WIDTH-1:0] countData,
  output logic                   terminalCount,
  output logic                   wrapPulse
);

  logic [COUNT_WIDTH:0] carry;
  logic                 railHigh;
  logic                 railLow;
  logic                 wrapPulse_q;
  logic                 wrapPulse_d;

  assign railHigh = DigitSupply[DIGIT_HIGH];
  assign railLow  = DigitSupply[DIGIT_LOW];

  // Enable is gated by the high rail so every constant in the chain comes from the supply.
  assign carry[0] = enableData & railHigh;

  for (genvar i = 0; i < COUNT_WIDTH; i++) begin : g_bit
    _and #(
      .WIDTH(2)
    ) u_carryAnd (
      .inputData ({carry[i], countData[i]}),
      .outputData(carry[i+1])
    );

    _counter_bit u_bit (
      .clk_i    (Clock),
      .rst_ni   (ResetN),
      .low_i    (railLow),
      .clear_i  (clearData),
      .load_i   (loadData),
      .loadBit_i(loadValue[i]),
      .carry_i  (carry[i]),
      .count_o  (countData[i])
    );
  end

  assign terminalCount = carry[COUNT_WIDTH];

  // terminalCount already includes enable, so it is exactly the wrap condition when not overridden.
  always_comb begin
    wrapPulse_d = terminalCount;
    if (clearData || loadData) begin
      wrapPulse_d = railLow;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wrapPulse_q <= 1'b0;
    end else begin
      wrapPulse_q <= wrapPulse_d;
    end
  end

  assign wrapPulse = wrapPulse_q;

endmodule : _counter
